// File: rtl/load_bin_ctrl_if.sv
// Clause memory bus between the bin loader and the clause store.
// Ports: read strobe/address/data (1-cycle latency), write strobe/address/data.
interface load_bin_ctrl_if #(
    parameter int WIDTH_ADDR = 18,
    parameter int WIDTH_DATA = 16
);
    logic                  mem_rd_en_o;
    logic [WIDTH_ADDR-1:0] mem_raddr_o;
    logic [WIDTH_DATA-1:0] mem_rdata_i;
    logic                  mem_wr_en_o;
    logic [WIDTH_ADDR-1:0] mem_waddr_o;
    logic [WIDTH_DATA-1:0] mem_wdata_o;

    modport master (
        output mem_rd_en_o, mem_raddr_o,
        output mem_wr_en_o, mem_waddr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_rd_en_o, mem_raddr_o,
        input  mem_wr_en_o, mem_waddr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/load_bin_ctrl.sv
// Bin loader: copies one bin of clauses plus var/lvl states into the
// solver engine, starts it, then writes the clauses back to memory.
// Ports: clk/rst; start_i with bin/level/state operands; busy/done and
// captured verdict; mem (clause memory bus); engine clause/state/control.
module load_bin_ctrl #(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_BIN_ID     = 15,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_i,
    input  logic [WIDTH_BIN_ID-1:0]                bin_id_i,
    input  logic [WIDTH_LVL-1:0]                   load_lvl_i,
    input  logic [WIDTH_LVL-1:0]                   base_lvl_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vs_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   ls_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   sat_o,
    output logic                                   unsat_o,
    output logic [WIDTH_LVL-1:0]                   bkt_lvl_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vs_o,
    load_bin_ctrl_if.master                        mem,
    output logic [NUM_CLAUSES-1:0]                 wr_carray_o,
    output logic [NUM_VARS*2-1:0]                  clause_o,
    output logic [NUM_CLAUSES-1:0]                 rd_carray_o,
    input  logic [NUM_VARS*2-1:0]                  clause_i,
    output logic [NUM_VARS-1:0]                    wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vars_states_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vars_states_i,
    output logic [NUM_LVLS-1:0]                    wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_o,
    output logic                                   start_core_o,
    output logic                                   base_lvl_en_o,
    output logic [WIDTH_LVL-1:0]                   cur_bin_num_o,
    output logic [WIDTH_LVL-1:0]                   load_lvl_o,
    output logic [WIDTH_LVL-1:0]                   base_lvl_o,
    input  logic                                   done_core_i,
    input  logic                                   sat_i,
    input  logic                                   unsat_i,
    input  logic [WIDTH_LVL-1:0]                   bkt_lvl_i
);
    localparam int CW = $clog2(NUM_CLAUSES);
    localparam int NW = $clog2(NUM_CLAUSES + 1);
    localparam int AW = WIDTH_BIN_ID + CW;
    localparam logic [NW-1:0] LAST = NW'(NUM_CLAUSES);

    typedef enum logic [2:0] {
        IDLE, LOAD_C, LOAD_S, START, WAIT, RD_C, DONE
    } state_t;

    state_t state, state_n;

    logic [NW-1:0]                         cnt;
    logic [CW-1:0]                         idx, idx_prev;
    logic                                  first, more;
    logic [WIDTH_BIN_ID-1:0]               bin_q;
    logic [WIDTH_LVL-1:0]                  load_q, base_q;
    logic [WIDTH_VAR_STATES*NUM_VARS-1:0]  vs_q;
    logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]  ls_q;
    logic                                  rd_en, wr_en;
    logic [AW-1:0]                         raddr, waddr;
    logic [NUM_VARS*2-1:0]                 wdata;

    // cnt walks 0..NUM_CLAUSES: the extra step drains the one-cycle
    // latency of the memory (load) or of the engine (readback).
    assign idx      = cnt[CW-1:0];
    assign idx_prev = CW'(cnt - 1'b1);
    assign first    = (cnt == '0);
    assign more     = (cnt != LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if ((state == LOAD_C || state == RD_C) && more)
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q     <= '0;
            load_q    <= '0;
            base_q    <= '0;
            vs_q      <= '0;
            ls_q      <= '0;
            sat_o     <= 1'b0;
            unsat_o   <= 1'b0;
            bkt_lvl_o <= '0;
            vs_o      <= '0;
        end else begin
            if (state == IDLE && start_i) begin
                bin_q  <= bin_id_i;
                load_q <= load_lvl_i;
                base_q <= base_lvl_i;
                vs_q   <= vs_i;
                ls_q   <= ls_i;
            end
            if (state == WAIT && done_core_i) begin
                sat_o     <= sat_i;
                unsat_o   <= unsat_i;
                bkt_lvl_o <= bkt_lvl_i;
                vs_o      <= vars_states_i;
            end
        end
    end

    always_comb begin
        state_n         = state;
        rd_en           = 1'b0;
        raddr           = '0;
        wr_en           = 1'b0;
        waddr           = '0;
        wdata           = '0;
        wr_carray_o     = '0;
        clause_o        = '0;
        rd_carray_o     = '0;
        wr_var_states_o = '0;
        vars_states_o   = '0;
        wr_lvl_states_o = '0;
        lvl_states_o    = '0;
        start_core_o    = 1'b0;
        base_lvl_en_o   = 1'b0;
        done_o          = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) state_n = LOAD_C;
            end
            LOAD_C: begin
                if (more) begin
                    rd_en = 1'b1;
                    raddr = {bin_q, idx};
                end
                if (!first) begin
                    wr_carray_o = NUM_CLAUSES'(1) << idx_prev;
                    clause_o    = mem.mem_rdata_i;
                end
                if (!more) state_n = LOAD_S;
            end
            LOAD_S: begin
                wr_var_states_o = '1;
                vars_states_o   = vs_q;
                wr_lvl_states_o = '1;
                lvl_states_o    = ls_q;
                state_n         = START;
            end
            START: begin
                start_core_o  = 1'b1;
                base_lvl_en_o = 1'b1;
                state_n       = WAIT;
            end
            WAIT: begin
                if (done_core_i) state_n = RD_C;
            end
            RD_C: begin
                if (more) rd_carray_o = NUM_CLAUSES'(1) << idx;
                if (!first) begin
                    wr_en = 1'b1;
                    waddr = {bin_q, idx_prev};
                    wdata = clause_i;
                end
                if (!more) state_n = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem.mem_rd_en_o = rd_en;
    assign mem.mem_raddr_o = raddr;
    assign mem.mem_wr_en_o = wr_en;
    assign mem.mem_waddr_o = waddr;
    assign mem.mem_wdata_o = wdata;

    assign busy_o        = (state != IDLE);
    assign cur_bin_num_o = WIDTH_LVL'(bin_q);
    assign load_lvl_o    = load_q;
    assign base_lvl_o    = base_q;
endmodule

// File: tb/tb_load_bin_ctrl.sv
// Scoreboard bench for load_bin_ctrl: directed loads/readbacks push the
// expected events; a negedge monitor pops and compares each DUT event.
module tb_load_bin_ctrl;
    localparam int NC = 8;
    localparam int K_RD = 0, K_WC = 1, K_LS = 2, K_ST = 3;
    localparam int K_RC = 4, K_WR = 5, K_DN = 6;

    localparam logic [151:0] V1  = {8{19'h12345}};
    localparam logic [127:0] L1  = {8{16'hbeef}};
    localparam logic [151:0] VE1 = {8{19'h70f0f}};
    localparam logic [151:0] V2  = {8{19'h0a5a5}};
    localparam logic [127:0] L2  = {8{16'h1234}};
    localparam logic [151:0] VE2 = {8{19'h33333}};
    localparam logic [151:0] V3  = {8{19'h7ffff}};
    localparam logic [127:0] L3  = {8{16'hc0de}};
    localparam logic [151:0] VE3 = {8{19'h40001}};

    typedef struct {
        int           kind;
        int           cyc;
        logic [151:0] d0;
        logic [151:0] d1;
    } ev_t;

    ev_t exp_q[$];

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [14:0]  bin_id_i = '0;
    logic [15:0]  load_lvl_i = '0;
    logic [15:0]  base_lvl_i = '0;
    logic [151:0] vs_i = '0;
    logic [127:0] ls_i = '0;
    logic         busy_o, done_o, sat_o, unsat_o;
    logic [15:0]  bkt_lvl_o;
    logic [151:0] vs_o;
    logic [7:0]   wr_carray_o, rd_carray_o;
    logic [15:0]  clause_o;
    logic [15:0]  clause_i = '0;
    logic [7:0]   wr_var_states_o, wr_lvl_states_o;
    logic [151:0] vars_states_o;
    logic [151:0] vars_states_i = '0;
    logic [127:0] lvl_states_o;
    logic         start_core_o, base_lvl_en_o;
    logic [15:0]  cur_bin_num_o, load_lvl_o, base_lvl_o;
    logic         done_core_i = 1'b0;
    logic         sat_i = 1'b0;
    logic         unsat_i = 1'b0;
    logic [15:0]  bkt_lvl_i = '0;
    logic [7:0]   eng_salt = '0;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    load_bin_ctrl_if #(.WIDTH_ADDR(18), .WIDTH_DATA(16)) mem ();

    load_bin_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .bin_id_i        (bin_id_i),
        .load_lvl_i      (load_lvl_i),
        .base_lvl_i      (base_lvl_i),
        .vs_i            (vs_i),
        .ls_i            (ls_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .sat_o           (sat_o),
        .unsat_o         (unsat_o),
        .bkt_lvl_o       (bkt_lvl_o),
        .vs_o            (vs_o),
        .mem             (mem),
        .wr_carray_o     (wr_carray_o),
        .clause_o        (clause_o),
        .rd_carray_o     (rd_carray_o),
        .clause_i        (clause_i),
        .wr_var_states_o (wr_var_states_o),
        .vars_states_o   (vars_states_o),
        .vars_states_i   (vars_states_i),
        .wr_lvl_states_o (wr_lvl_states_o),
        .lvl_states_o    (lvl_states_o),
        .start_core_o    (start_core_o),
        .base_lvl_en_o   (base_lvl_en_o),
        .cur_bin_num_o   (cur_bin_num_o),
        .load_lvl_o      (load_lvl_o),
        .base_lvl_o      (base_lvl_o),
        .done_core_i     (done_core_i),
        .sat_i           (sat_i),
        .unsat_i         (unsat_i),
        .bkt_lvl_i       (bkt_lvl_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] memf(logic [17:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    // clause memory: registered read, one cycle of latency
    always @(posedge clk)
        if (mem.mem_rd_en_o) mem.mem_rdata_i <= memf(mem.mem_raddr_o);

    // engine clause array: answers a read one cycle later
    always @(posedge clk)
        for (int k = 0; k < NC; k++)
            if (rd_carray_o[k]) clause_i <= {eng_salt, 5'd0, 3'(k)};

    function automatic string kname(int k);
        case (k)
            K_RD:    return "mem_read";
            K_WC:    return "wr_carray";
            K_LS:    return "state_load";
            K_ST:    return "start_core";
            K_RC:    return "rd_carray";
            K_WR:    return "mem_write";
            default: return "done";
        endcase
    endfunction

    task automatic obs(int k, logic [151:0] a, logic [151:0] b);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected %s cycle %0d: got %0h/%0h, required none",
                     kname(k), cyc, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.d0 !== a || e.d1 !== b) begin
                n_err++;
                $display("FAIL %s cycle %0d: got %0h/%0h, required %s cycle %0d %0h/%0h",
                         kname(k), cyc, a, b, kname(e.kind), e.cyc, e.d0, e.d1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mem.mem_rd_en_o)
            obs(K_RD, 152'(mem.mem_raddr_o), '0);
        if (wr_carray_o != '0)
            obs(K_WC, 152'(wr_carray_o), 152'(clause_o));
        if (wr_var_states_o != '0 || wr_lvl_states_o != '0)
            obs(K_LS, vars_states_o,
                152'({lvl_states_o, wr_var_states_o, wr_lvl_states_o}));
        if (start_core_o || base_lvl_en_o)
            obs(K_ST, 152'({start_core_o, base_lvl_en_o, cur_bin_num_o,
                            load_lvl_o, base_lvl_o}), '0);
        if (rd_carray_o != '0)
            obs(K_RC, 152'(rd_carray_o), '0);
        if (mem.mem_wr_en_o)
            obs(K_WR, 152'(mem.mem_waddr_o), 152'(mem.mem_wdata_o));
        if (done_o)
            obs(K_DN, vs_o, 152'({sat_o, unsat_o, bkt_lvl_o}));
    end

    task automatic chk(string nm, logic [151:0] act, logic [151:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(int c);
        while (cyc < c) tick();
    endtask

    task automatic push(int k, int c, logic [151:0] a, logic [151:0] b);
        exp_q.push_back('{kind: k, cyc: c, d0: a, d1: b});
    endtask

    task automatic push_load(int c0, logic [14:0] bin, logic [15:0] lvl,
                             logic [15:0] base, logic [151:0] vs,
                             logic [127:0] ls, int nj);
        for (int j = 0; j <= nj; j++) begin
            logic [2:0] jj, jp;
            jj = 3'(j);
            jp = 3'(j - 1);
            if (j < NC)
                push(K_RD, c0 + 1 + j, 152'({bin, jj}), '0);
            if (j >= 1)
                push(K_WC, c0 + 1 + j, 152'(8'b1 << jp), 152'(memf({bin, jp})));
        end
        if (nj == NC) begin
            push(K_LS, c0 + 10, vs, 152'({ls, 8'hff, 8'hff}));
            push(K_ST, c0 + 11, 152'({2'b11, 1'b0, bin, lvl, base}), '0);
        end
    endtask

    task automatic issue_load(logic [14:0] bin, logic [15:0] lvl,
                              logic [15:0] base, logic [151:0] vs,
                              logic [127:0] ls, int nj, output int c0);
        c0 = cyc;
        start_i    = 1'b1;
        bin_id_i   = bin;
        load_lvl_i = lvl;
        base_lvl_i = base;
        vs_i       = vs;
        ls_i       = ls;
        push_load(c0, bin, lvl, base, vs, ls, nj);
        tick();
        start_i = 1'b0;
    endtask

    task automatic issue_done(logic s, logic u, logic [15:0] bkt,
                              logic [151:0] vse, logic [7:0] salt,
                              logic [14:0] bin, output int d);
        d = cyc;
        eng_salt      = salt;
        done_core_i   = 1'b1;
        sat_i         = s;
        unsat_i       = u;
        bkt_lvl_i     = bkt;
        vars_states_i = vse;
        for (int j = 0; j <= NC; j++) begin
            logic [2:0] jj, jp;
            jj = 3'(j);
            jp = 3'(j - 1);
            if (j < NC)
                push(K_RC, d + 1 + j, 152'(8'b1 << jj), '0);
            if (j >= 1)
                push(K_WR, d + 1 + j, 152'({bin, jp}),
                     152'({salt, 5'd0, jp}));
        end
        push(K_DN, d + 10, vse, 152'({s, u, bkt}));
        tick();
        done_core_i   = 1'b0;
        sat_i         = 1'b0;
        unsat_i       = 1'b0;
        bkt_lvl_i     = '0;
        vars_states_i = '0;
    endtask

    initial begin
        int c0, d;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 152'(busy_o), 0);
        chk("rst_done", 152'(done_o), 0);
        chk("rst_verdict", 152'({sat_o, unsat_o, bkt_lvl_o}), 0);
        chk("rst_vs", vs_o, 0);
        chk("rst_raddr", 152'(mem.mem_raddr_o), 0);
        chk("rst_cur_bin", 152'(cur_bin_num_o), 0);
        rst = 1'b0;
        tick();

        // bin 3 load with ignored starts / done_core, sat readback
        issue_load(15'd3, 16'h0011, 16'h0002, V1, L1, NC, c0);
        chk("busy_loading", 152'(busy_o), 1);
        wait_to(c0 + 3);
        start_i     = 1'b1;
        bin_id_i    = 15'd99;
        done_core_i = 1'b1;
        tick();
        start_i     = 1'b0;
        done_core_i = 1'b0;
        wait_to(c0 + 13);
        chk("bin_held_wait", 152'(cur_bin_num_o), 3);
        start_i  = 1'b1;
        bin_id_i = 15'd77;
        tick();
        start_i = 1'b0;
        wait_to(c0 + 16);
        issue_done(1'b1, 1'b0, 16'd5, VE1, 8'h3c, 15'd3, d);
        wait_to(d + 10);
        start_i  = 1'b1;
        bin_id_i = 15'd11;
        tick();
        start_i = 1'b0;
        tick();
        chk("idle_after_done", 152'(busy_o), 0);
        chk("verdict_hold", 152'({sat_o, unsat_o, bkt_lvl_o}), 152'({2'b10, 16'd5}));

        // reset while LOAD_C presents index 4
        issue_load(15'd5, 16'h0022, 16'h0001, V2, L2, 4, c0);
        wait_to(c0 + 5);
        rst = 1'b1;
        tick();
        chk("abort_busy", 152'(busy_o), 0);
        chk("abort_strobes", 152'({mem.mem_rd_en_o, mem.mem_wr_en_o, wr_carray_o,
                                   rd_carray_o, start_core_o, wr_var_states_o}), 0);
        chk("abort_verdict", 152'({sat_o, unsat_o, bkt_lvl_o}), 0);
        rst = 1'b0;
        tick();

        // fresh load of bin 6, unsat verdict
        issue_load(15'd6, 16'h0100, 16'h0003, V2, L2, NC, c0);
        wait_to(c0 + 12);
        issue_done(1'b0, 1'b1, 16'd0, VE2, 8'hc5, 15'd6, d);
        wait_to(d + 10);
        chk("done_pulse", 152'(done_o), 1);
        chk("unsat_verdict", 152'({sat_o, unsat_o, bkt_lvl_o}), 152'({2'b01, 16'd0}));
        start_i  = 1'b1;
        bin_id_i = 15'd11;
        tick();

        // back-to-back start on the IDLE cycle, all-ones bin id
        issue_load(15'h7fff, 16'hffff, 16'h8000, V3, L3, NC, c0);
        wait_to(c0 + 12);
        issue_done(1'b1, 1'b0, 16'h00ff, VE3, 8'h81, 15'h7fff, d);
        wait_to(d + 10);
        chk("boundary_bin", 152'(cur_bin_num_o), 152'(16'h7fff));
        repeat (4) tick();
        chk("queue_drained", 152'(exp_q.size()), 0);
        chk("final_idle", 152'({busy_o, done_o}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
